// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit: ID-stage forwarding selects and load-use stall/flush FSM.
// Optional macro HAZARD_PERF_CNT_EN adds stall_cycles / fwd_events perf counters.
module pipe_hazard_unit #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        hold,
    input  logic                        id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]   id_src,
    input  logic [NUM_SRC-1:0]          id_src_used,
    input  logic [REG_AW-1:0]           id_ex_rd,
    input  logic [REG_AW-1:0]           ex_mem_rd,
    input  logic [REG_AW-1:0]           mem_wb_rd,
    input  logic                        id_ex_regwrite,
    input  logic                        ex_mem_regwrite,
    input  logic                        id_ex_memread,
    output logic [2*NUM_SRC-1:0]        fwd_sel,
    output logic                        stall,
    output logic                        flush_ex
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]                 stall_cycles,
    output logic [31:0]                 fwd_events
`endif
);

    localparam int unsigned CNT_W = $clog2(LOAD_LAT) + 1;
    localparam int unsigned SEL_W = 2 * NUM_SRC;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_STALL = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [SEL_W-1:0]   r_fwd_sel;
    logic [SEL_W-1:0]   w_fwd_nxt;
    logic               r_flush_hold;
    logic               w_detect;
    logic               w_stall;
    logic               w_unused_ok;

    // MEM/WB results reach ID through the write-first regfile, so mem_wb_rd needs no select.
    assign w_unused_ok = ^mem_wb_rd;

    // Per-source forwarding select and load-use detection.
    always_comb begin
        w_fwd_nxt = '0;
        w_detect  = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (id_valid && id_src_used[i] && (id_src[i*REG_AW +: REG_AW] != '0)) begin
                if (id_ex_regwrite && (id_ex_rd == id_src[i*REG_AW +: REG_AW])) begin
                    w_fwd_nxt[2*i +: 2] = 2'b10;
                end else if (ex_mem_regwrite && (ex_mem_rd == id_src[i*REG_AW +: REG_AW])) begin
                    w_fwd_nxt[2*i +: 2] = 2'b01;
                end
                if (id_ex_memread && (id_ex_rd == id_src[i*REG_AW +: REG_AW])) begin
                    w_detect = 1'b1;
                end
            end
        end
    end

    // Load-use FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else if (!hold) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Load-use FSM next state; the detect cycle itself is the first bubble.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stall = w_detect;
                if (w_detect && (LOAD_LAT > 1)) begin
                    w_state_nxt = S_STALL;
                    w_cnt_nxt   = CNT_W'(LOAD_LAT - 1);
                end
            end
            S_STALL: begin
                w_stall   = 1'b1;
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // EX-stage selects plus the flush value to replay while frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fwd_sel    <= '0;
            r_flush_hold <= 1'b0;
        end else if (!hold) begin
            r_fwd_sel    <= w_stall ? '0 : w_fwd_nxt;
            r_flush_hold <= w_stall;
        end
    end

    assign fwd_sel  = r_fwd_sel;
    assign stall    = hold | w_stall;
    assign flush_ex = hold ? r_flush_hold : w_stall;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_fwd_events;

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_fwd_events   <= '0;
        end else if (!hold) begin
            if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (!w_stall && (w_fwd_nxt != '0) && (r_fwd_events != 32'hFFFF_FFFF)) begin
                r_fwd_events <= r_fwd_events + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign fwd_events   = r_fwd_events;
`endif

endmodule
